// File: rtl/hpm_overflow_ctrl.sv
// ---------------------------------------------------------------------------
// hpm_overflow_ctrl
//   Sticky per-counter overflow (OF) tracking for mhpmcounter3..(3+NumCnt-1),
//   local counter-overflow interrupt (LCOFI) generation, OF views through
//   mhpmevent (XLEN=64) / mhpmeventh (XLEN=32) and scountovf, and optional
//   freezing of overflowed counters.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   wrap_i       per-counter wrap pulse from the counter block
//   addr_i       CSR address (read and write)
//   we_i         CSR write enable
//   data_i       CSR write data
//   lcofi_clr_i  software clear of the pending LCOFI
//   data_o       CSR read data for addr_i (combinational)
//   hit_o        addr_i decodes to an OF location or scountovf (combinational)
//   irq_o        LCOFI pending (registered)
//   freeze_o     per-counter count inhibit (combinational from OF state)
// ---------------------------------------------------------------------------
module hpm_overflow_ctrl #(
    parameter int unsigned NumCnt     = 6,
    parameter int unsigned XLEN       = 64,
    parameter bit          FreezeOnOf = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumCnt-1:0] wrap_i,
    input  logic [11:0]       addr_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic              lcofi_clr_i,
    output logic [XLEN-1:0]   data_o,
    output logic              hit_o,
    output logic              irq_o,
    output logic [NumCnt-1:0] freeze_o
);

    // OF lives in the top bit of mhpmevent (RV64) or mhpmeventh (RV32)
    localparam logic [11:0] OfBase        = (XLEN == 64) ? 12'h323 : 12'h723;
    localparam logic [11:0] ScountovfAddr = 12'hDA0;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [NumCnt-1:0] of_q, of_d;
    logic [NumCnt-1:0] of_sel;
    logic [NumCnt-1:0] hw_event;
    logic              any_hw_event;
    logic              sc_hit;
    logic              of_wbit;

    // Only the OF bit of the write data is meaningful here
    logic unused_data;
    assign unused_data = ^data_i[XLEN-2:0];
    assign of_wbit     = data_i[XLEN-1];

    // One-hot decode of the per-counter OF location
    always_comb begin
        of_sel = '0;
        for (int unsigned k = 0; k < NumCnt; k++) begin
            if (addr_i == OfBase + 12'(k)) begin
                of_sel[k] = 1'b1;
            end
        end
    end

    assign sc_hit = (addr_i == ScountovfAddr);

    // Only a hardware 0->1 transition counts as an overflow event
    assign hw_event     = wrap_i & ~of_q;
    assign any_hw_event = |hw_event;

    // OF update: wrap beats software write beats hold
    always_comb begin
        of_d = of_q;
        for (int unsigned k = 0; k < NumCnt; k++) begin
            if (wrap_i[k]) begin
                of_d[k] = 1'b1;
            end else if (we_i && of_sel[k]) begin
                of_d[k] = of_wbit;
            end
        end
    end

    // Interrupt FSM next state; a new event wins over a concurrent clear
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_hw_event) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (lcofi_clr_i && !any_hw_event) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            of_q    <= '0;
        end else begin
            state_q <= state_d;
            of_q    <= of_d;
        end
    end

    assign irq_o    = (state_q == PEND);
    assign freeze_o = FreezeOnOf ? of_q : '0;

    // CSR read mux; non-OF fields always read as zero
    always_comb begin
        data_o = '0;
        if (sc_hit) begin
            data_o = XLEN'({of_q, 3'b000});
        end else if (|of_sel) begin
            data_o[XLEN-1] = |(of_sel & of_q);
        end
    end

    assign hit_o = sc_hit | (|of_sel);

endmodule

// File: doc/hpm_overflow_ctrl.md
Name: hpm_overflow_ctrl

Overview:
- Sits directly downstream of the hardware performance counter block and consumes its per-counter wrap pulses.
- Maintains one sticky overflow (OF) bit per mhpmcounter3..(3+NumCnt-1), Sscofpmf-style.
- Raises the local counter-overflow interrupt request (LCOFI) towards the CSR regfile and exposes OF state through the mhpmevent/mhpmeventh and scountovf CSR views.
- Optionally freezes overflowed counters by feeding inhibit bits back to the counter block.

Parameters:
- NumCnt, 6, number of generic counters covered (counter k maps to mhpmcounter(3+k)); range 1..29.
- XLEN, 64, CSR data width; only 32 or 64 is legal.
- FreezeOnOf, 1, when 1 a set OF bit asserts freeze_o for that counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- wrap_i  in  NumCnt  pulse: counter k wrapped from all-ones to 0 this cycle.
- addr_i  in  12  CSR address.
- we_i  in  1  CSR write enable.
- data_i  in  XLEN  CSR write data.
- lcofi_clr_i  in  1  software clear of mip.LCOFIP.
- data_o  out  XLEN  CSR read data for addr_i.
- hit_o  out  1  addr_i decodes to a CSR owned by this block.
- irq_o  out  1  LCOFI pending.
- freeze_o  out  NumCnt  per-counter count inhibit.

Behaviour:
- Reset (rst_i high at a clk_i edge): of_q = 0, state = IDLE, irq_o = 0.
  - freeze_o and data_o are combinational from of_q and addr_i. After reset they read 0, apart from non-OF fields on reads, which are always 0.
  - Reset overrides any concurrent wrap_i or we_i.
- OF bit locations:
  - XLEN=64: bit 63 of mhpmevent(3+k) at 0x323+k.
  - XLEN=32: bit 31 of mhpmeventh(3+k) at 0x723+k. In XLEN=64, 0x723+k is not decoded (hit_o=0).
  - scountovf at 0xDA0 is read-only: bit (3+k) = of_q[k]; all other bits read 0.
- of_q[k] update each cycle, in priority order:
  1. wrap_i[k] -> 1.
  2. Else a CSR write to the OF location of counter k -> the written OF bit.
  3. Else hold.
  - Writes to scountovf are ignored.
- Hardware overflow event: wrap_i[k] && !of_q[k] (a 0->1 transition caused by hardware).
  - A wrap while OF is already set is not a new event.
  - A software write setting OF never raises the interrupt.
- Interrupt FSM, 2 states:
  - IDLE -> PEND: any hardware overflow event.
  - PEND -> IDLE: lcofi_clr_i with no hardware overflow event in the same cycle. Simultaneous set and clear ends in PEND (set wins).
  - lcofi_clr_i in IDLE has no effect.
  - irq_o = (state == PEND), registered: it asserts on the cycle after the wrap.
- Clearing OF bits does not clear the interrupt; clearing the interrupt does not clear OF bits.
- freeze_o[k] = FreezeOnOf && of_q[k].
  - With FreezeOnOf=0, freeze_o is constant 0.
  - freeze_o rises on the cycle after the wrap, so the counter block may count at most one extra event after wrapping.
- Reads:
  - data_o is valid in the same cycle as addr_i.
  - OF location: data_o = OF bit in position, other bits 0.
  - Unmapped address: data_o = 0, hit_o = 0.
  - hit_o is independent of we_i.
- Simultaneous wraps on several counters: all corresponding OF bits set in the same cycle; a single IDLE->PEND transition.

Test Plan:
- Reset, then idle 5 cycles -> irq_o=0, freeze_o=0, scountovf read = 0.
- XLEN=64: wrap_i=6'b000100 for 1 cycle -> next cycle of_q[2]=1, irq_o=1, freeze_o=6'b000100; read 0x325 -> data_o=0x8000_0000_0000_0000; read 0xDA0 -> data_o=0x20.
- With state PEND and of_q[2]=1: lcofi_clr_i=1 and wrap_i[0]=1 in the same cycle -> irq_o stays 1, of_q=6'b000101. Then lcofi_clr_i alone -> irq_o=0 next cycle, of_q unchanged.
- Write 0x323 with data_i=0 in the same cycle as wrap_i[0]=1 -> of_q[0]=1 and irq_o=1 next cycle. Write 0x323 with data_i=0 alone -> of_q[0]=0 and irq_o unchanged.
- Software sets OF: write 0x324 with bit 63 set -> of_q[1]=1, irq_o=0. A later wrap_i[1] -> irq_o stays 0 (no 0->1 transition).
- XLEN=32, FreezeOnOf=0: wrap_i[5] -> of_q[5]=1, freeze_o=0; read 0x728 -> data_o=0x8000_0000; read 0x328 -> OF bit absent (bit 31 = 0); reset asserted while PEND -> irq_o=0 and of_q=0 next cycle.
